fsmc_sram_slave: RTL and testbench

Synthesizable responder for the external side of the FSMC NOR/SRAM bank interface. It decodes chip-select, output-enable, write-enable and byte-lane strobes driven by the FSMC controller and serves 16-bit reads and writes from an internal register array. It generates NWAIT wait states and flags protocol violations. It sits on the pad side of the FSMC pins, in the same clock domain, and is used as an on-chip memory target and as the loopback partner for controller verification.

---
 rtl/fsmc_sram_slave.sv | 111 +++++++++++
 tb/tb_fsmc_sram_slave.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fsmc_sram_slave.sv
// fsmc_sram_slave: FSMC NOR/SRAM bank responder serving 16-bit reads/writes from an internal array.
// Ports: hclk, hresetn (async active-low); fsmc_a/fsmc_do/fsmc_noe/fsmc_nwe/fsmc_ne/fsmc_nbl from the
// controller; fsmc_di registered read data, fsmc_nwait wait request, proto_err violation pulse, busy.
// Optional macro FSMC_SLV_NWAIT_EN enables the WAIT state and NWAIT generation.
module fsmc_sram_slave #(
  parameter int AW       = 10,
  parameter int WAIT_CYC = 2,
  parameter int NE_IDX   = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [25:0] fsmc_a,
  input  logic [15:0] fsmc_do,
  input  logic        fsmc_noe,
  input  logic        fsmc_nwe,
  input  logic [4:1]  fsmc_ne,
  input  logic [1:0]  fsmc_nbl,
  output logic [15:0] fsmc_di,
  output logic        fsmc_nwait,
  output logic        proto_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, WRITE} state_e;
  state_e          state_q;
  logic            ne_q, noe_q, nwe_q;
  logic [AW-1:0]   a_q;
  logic [15:0]     d_q, wdata_q;
  logic [1:0]      nbl_q, lanes_q;
  logic [15:0]     mem [2**AW];
  logic            commit;
  logic            unused_pins;
  assign unused_pins = ^{fsmc_a[25:AW], fsmc_ne};
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      ne_q  <= 1'b1;
      noe_q <= 1'b1;
      nwe_q <= 1'b1;
      a_q   <= '0;
      d_q   <= '0;
      nbl_q <= 2'b11;
    end else begin
      ne_q  <= fsmc_ne[NE_IDX];
      noe_q <= fsmc_noe;
      nwe_q <= fsmc_nwe;
      a_q   <= fsmc_a[AW-1:0];
      d_q   <= fsmc_do;
      nbl_q <= fsmc_nbl;
    end
  assign commit = (state_q == WRITE) && (nwe_q || ne_q);
  always_ff @(posedge hclk) begin
    if (commit && lanes_q[0]) mem[a_q][7:0]  <= wdata_q[7:0];
    if (commit && lanes_q[1]) mem[a_q][15:8] <= wdata_q[15:8];
  end
`ifdef FSMC_SLV_NWAIT_EN
  logic [3:0] cnt_q;
  logic       dir_wr_q;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      cnt_q    <= '0;
      dir_wr_q <= 1'b0;
    end else if (state_q == IDLE && !ne_q && (noe_q ^ nwe_q)) begin
      cnt_q    <= 4'(WAIT_CYC - 1);
      dir_wr_q <= !nwe_q;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  assign fsmc_nwait = state_q != WAIT;
`else
  localparam int unused_wait_cyc = WAIT_CYC;
  assign fsmc_nwait = 1'b1;
`endif
  assign busy = state_q != IDLE;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state_q   <= IDLE;
      fsmc_di   <= '0;
      proto_err <= 1'b0;
      wdata_q   <= '0;
      lanes_q   <= '0;
    end else begin
      proto_err <= 1'b0;
      // capture whenever NWE is low so the commit uses the last sampled data
      if (!ne_q && !nwe_q) begin
        wdata_q <= d_q;
        lanes_q <= ~nbl_q;
      end
      case (state_q)
        IDLE:
          if (!ne_q && !noe_q && !nwe_q) proto_err <= 1'b1;
          else if (!ne_q && (noe_q ^ nwe_q))
`ifdef FSMC_SLV_NWAIT_EN
            state_q <= (WAIT_CYC != 0) ? WAIT : (nwe_q ? READ : WRITE);
`else
            state_q <= nwe_q ? READ : WRITE;
`endif
`ifdef FSMC_SLV_NWAIT_EN
        WAIT:
          if (ne_q) state_q <= IDLE;
          else if (cnt_q == 4'd0) state_q <= dir_wr_q ? WRITE : READ;
`endif
        READ:
          if (ne_q || noe_q) state_q <= IDLE;
          else fsmc_di <= mem[a_q];
        WRITE: begin
          if (!noe_q) proto_err <= 1'b1;
          if (nwe_q || ne_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fsmc_sram_slave.sv
// tb_fsmc_sram_slave: directed bench for fsmc_sram_slave with a reference array and read scoreboard.
module tb_fsmc_sram_slave;
  localparam int AW = 10;
  localparam int WC = 3;
`ifdef FSMC_SLV_NWAIT_EN
  localparam int EFF = WC;
`else
  localparam int EFF = 0;
`endif
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [25:0] fa = '0;
  logic [15:0] fdo = '0;
  logic        noe = 1'b1, nwe = 1'b1;
  logic [4:1]  ne = 4'hF;
  logic [1:0]  fnbl = 2'b11;
  logic [15:0] di;
  logic        nwait, perr, busy;
  logic [15:0] model_mem [1024];
  logic [15:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  fsmc_sram_slave #(.AW(AW), .WAIT_CYC(WC), .NE_IDX(1)) dut (
    .hclk(hclk), .hresetn(hresetn), .fsmc_a(fa), .fsmc_do(fdo), .fsmc_noe(noe), .fsmc_nwe(nwe),
    .fsmc_ne(ne), .fsmc_nbl(fnbl), .fsmc_di(di), .fsmc_nwait(nwait), .proto_err(perr), .busy(busy)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(inout int lo);
    @(posedge hclk);
    @(negedge hclk);
    if (!nwait) lo++;
  endtask

  task automatic wr(input logic [25:0] addr, input logic [15:0] data, input logic [1:0] nbl);
    int lo = 0;
    fa = addr; fdo = data; fnbl = nbl; ne[1] = 1'b0; nwe = 1'b0;
    repeat (EFF + 3) cyc(lo);
    ne[1] = 1'b1; nwe = 1'b1;
    repeat (3) cyc(lo);
    if (!nbl[0]) model_mem[addr[9:0]][7:0] = data[7:0];
    if (!nbl[1]) model_mem[addr[9:0]][15:8] = data[15:8];
    chk("wr_nwait_cycles", 16'(lo), 16'(EFF));
  endtask

  task automatic rd(input logic [25:0] addr, input string tag);
    int lo = 0;
    fa = addr; ne[1] = 1'b0; noe = 1'b0;
    exp_q.push_back(model_mem[addr[9:0]]);
    repeat (EFF + 3) cyc(lo);
    chk(tag, di, exp_q.pop_front());
    ne[1] = 1'b1; noe = 1'b1;
    repeat (3) cyc(lo);
    chk("rd_nwait_cycles", 16'(lo), 16'(EFF));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo = 0;
    int pcnt = 0;
    int bcnt = 0;
    repeat (3) @(negedge hclk);
    chk("rst_di", di, 16'h0000);
    chk("rst_nwait", 16'(nwait), 16'd1);
    chk("rst_perr", 16'(perr), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    hresetn = 1'b1;
    repeat (2) @(negedge hclk);
    wr(26'h003, 16'hA55A, 2'b00);
    rd(26'h003, "full_write_rd");
    wr(26'h010, 16'h1234, 2'b00);
    wr(26'h010, 16'hFFEE, 2'b10);
    rd(26'h010, "byte_lane_rd");
    chk("byte_lane_const", di, 16'h12EE);
    fa = 26'h003; fdo = 16'h1111; fnbl = 2'b00; ne[1] = 1'b0; noe = 1'b0; nwe = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    ne[1] = 1'b1; noe = 1'b1; nwe = 1'b1;
    if (perr) pcnt++;
    if (busy) bcnt++;
    repeat (5) begin
      cyc(lo);
      if (perr) pcnt++;
      if (busy) bcnt++;
    end
    chk("proto_pulses", 16'(pcnt), 16'd1);
    chk("proto_busy", 16'(bcnt), 16'd0);
    rd(26'h003, "proto_unchanged_rd");
    wr(26'h020, 16'hBEEF, 2'b00);
    rd(26'h020, "beef_rd");
`ifdef FSMC_SLV_NWAIT_EN
    fa = 26'h020; fdo = 16'h0000; fnbl = 2'b00; ne[1] = 1'b0; nwe = 1'b0;
    repeat (2) cyc(lo);
    chk("abort_in_wait", 16'(nwait), 16'd0);
    ne[1] = 1'b1; nwe = 1'b1;
    repeat (4) cyc(lo);
    chk("abort_idle", 16'(busy), 16'd0);
    rd(26'h020, "abort_rd");
`endif
    wr(26'h400, 16'hC0DE, 2'b00);
    rd(26'h000, "wrap_rd");
    fa = 26'h020; fdo = 16'h7777; fnbl = 2'b00; ne[1] = 1'b0; nwe = 1'b0;
    repeat (EFF + 3) cyc(lo);
    chk("midwr_busy", 16'(busy), 16'd1);
    hresetn = 1'b0;
    ne[1] = 1'b1; nwe = 1'b1;
    #1;
    chk("midrst_di", di, 16'h0000);
    chk("midrst_nwait", 16'(nwait), 16'd1);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_perr", 16'(perr), 16'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (2) @(negedge hclk);
    rd(26'h020, "midrst_no_commit_rd");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
